// File: rtl/note_sched_if.sv
// Key inputs and tone-generator control bundle for the note scheduler.
interface note_sched_if;
  logic [11:0] keys;
  logic [15:0] half_period;
  logic        gen_load;
  logic        gen_en;
  logic [3:0]  note_idx;
  logic [11:0] key_stable;

  modport master (input keys, output half_period, gen_load, gen_en, note_idx, key_stable);
  modport slave  (output keys, input half_period, gen_load, gen_en, note_idx, key_stable);
endinterface

// File: rtl/note_sched.sv
// Debounces 12 note keys and sequences one shared tone generator:
// lowest pressed key wins, no preemption while held, timed release tail.
module note_deb #(
  parameter int DEB_COUNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic keyRaw,
  output logic keyStable
);
  localparam int CW = $clog2(DEB_COUNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_COUNT - 1);

  logic [1:0]    syncQ;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncQ     <= '0;
      cnt       <= '0;
      keyStable <= 1'b0;
    end else begin
      syncQ <= {syncQ[0], keyRaw};
      if (tick) begin
        if (syncQ[1] == keyStable) cnt <= '0;
        else if (cnt == CNT_LAST) begin
          keyStable <= syncQ[1];
          cnt       <= '0;
        end else cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module note_sched #(
  parameter int SAMPLE_DIV = 25000,
  parameter int DEB_COUNT  = 4,
  parameter int REL_TICKS  = 50
) (
  input logic         clk,
  input logic         rst,
  note_sched_if.master bus
);
  localparam int NUM_KEYS = 12;
  localparam int PW = $clog2(SAMPLE_DIV + 1);
  localparam int RW = $clog2(REL_TICKS + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SAMPLE_DIV - 1);
  localparam logic [RW-1:0] REL_LAST = RW'(REL_TICKS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, RELEASE} state_t;

  state_t              state, stateNext;
  logic [PW-1:0]       preCnt;
  logic                tick;
  logic [NUM_KEYS-1:0] keyStable;
  logic [3:0]          noteIdx;
  logic [15:0]         halfPeriod;
  logic [RW-1:0]       relCnt;
  logic                latchNote, relClr, relInc;

  function automatic logic [15:0] halfTab(input logic [3:0] i);
    case (i)
      4'd0:    halfTab = 16'd47778;
      4'd1:    halfTab = 16'd45097;
      4'd2:    halfTab = 16'd42566;
      4'd3:    halfTab = 16'd40177;
      4'd4:    halfTab = 16'd37922;
      4'd5:    halfTab = 16'd35793;
      4'd6:    halfTab = 16'd33784;
      4'd7:    halfTab = 16'd31888;
      4'd8:    halfTab = 16'd30098;
      4'd9:    halfTab = 16'd28409;
      4'd10:   halfTab = 16'd26815;
      4'd11:   halfTab = 16'd25310;
      default: halfTab = 16'd47778;
    endcase
  endfunction

  function automatic logic [3:0] lowestIdx(input logic [NUM_KEYS-1:0] ks);
    lowestIdx = 4'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (ks[i]) lowestIdx = 4'(i);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) preCnt <= '0;
    else     preCnt <= tick ? '0 : preCnt + 1'b1;
  end
  assign tick = (preCnt == PRE_LAST);

  note_deb #(.DEB_COUNT(DEB_COUNT)) uDeb [NUM_KEYS-1:0] (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .keyRaw   (bus.keys),
    .keyStable(keyStable)
  );

  // A newly stable key in RELEASE beats the tail expiring on the same cycle.
  always_comb begin
    stateNext = state;
    latchNote = 1'b0;
    relClr    = 1'b0;
    relInc    = 1'b0;
    case (state)
      IDLE: if (|keyStable) begin
        latchNote = 1'b1;
        stateNext = LOAD;
      end
      LOAD: stateNext = PLAY;
      PLAY: if (!keyStable[noteIdx]) begin
        relClr    = 1'b1;
        stateNext = RELEASE;
      end
      RELEASE: begin
        if (|keyStable) begin
          latchNote = 1'b1;
          stateNext = LOAD;
        end else if (tick) begin
          if (relCnt == REL_LAST) stateNext = IDLE;
          else                    relInc    = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      noteIdx    <= 4'd0;
      halfPeriod <= 16'd47778;
      relCnt     <= '0;
    end else begin
      state <= stateNext;
      if (latchNote) begin
        noteIdx    <= lowestIdx(keyStable);
        halfPeriod <= halfTab(lowestIdx(keyStable));
      end
      if (relClr)      relCnt <= '0;
      else if (relInc) relCnt <= relCnt + 1'b1;
    end
  end

  // Decoded straight from the state register so reset kills them immediately.
  assign bus.gen_en      = (state != IDLE);
  assign bus.gen_load    = (state == LOAD);
  assign bus.note_idx    = noteIdx;
  assign bus.half_period = halfPeriod;
  assign bus.key_stable  = keyStable;
endmodule

// File: tb/tb_note_sched.sv
// Scoreboarded bench for note_sched: each expected generator load is queued
// when its key is driven and checked when gen_load fires.
module tb_note_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  note_sched_if nif();

  note_sched #(.SAMPLE_DIV(4), .DEB_COUNT(2), .REL_TICKS(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(nif)
  );

  typedef struct packed {
    logic [3:0]  idx;
    logic [15:0] hp;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;
  int   loadCnt  = 0;
  logic prevLoad = 1'b0;
  int   hpTab [12] = '{47778, 45097, 42566, 40177, 37922, 35793,
                       33784, 31888, 30098, 28409, 26815, 25310};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input int i);
    exp_t e;
    e.idx = 4'(i);
    e.hp  = 16'(hpTab[i]);
    expQ.push_back(e);
  endtask

  task automatic waitKs(input logic [11:0] val, input int maxCyc, input string tag);
    int n = 0;
    while (nif.key_stable !== val && n < maxCyc) begin
      cyc(1);
      n++;
    end
    chk(tag, nif.key_stable, val);
  endtask

  task automatic waitLoad(input int cnt, input int maxCyc, input string tag);
    int n = 0;
    while (loadCnt < cnt && n < maxCyc) begin
      cyc(1);
      n++;
    end
    chk(tag, loadCnt, cnt);
  endtask

  // Scoreboard side: every load must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && nif.gen_load) begin
      loadCnt <= loadCnt + 1;
      chk("noDblLoad", prevLoad, 0);
      chk("enInLoad", nif.gen_en, 1);
      chk("loadExpected", expQ.size() != 0, 1);
      if (expQ.size() != 0) begin
        chk("loadIdx", nif.note_idx, expQ[0].idx);
        chk("loadHp", nif.half_period, expQ[0].hp);
        void'(expQ.pop_front());
      end
    end
    prevLoad <= rst ? 1'b0 : nif.gen_load;
  end

  initial begin
    logic [11:0] ksOr;
    logic        enOr;
    int          ld;

    nif.keys = '0;
    cyc(2);
    chk("rstEn", nif.gen_en, 0);
    chk("rstLoad", nif.gen_load, 0);
    chk("rstIdx", nif.note_idx, 0);
    chk("rstHp", nif.half_period, 47778);
    chk("rstKs", nif.key_stable, 0);
    rst = 1'b0;
    cyc(2);

    // single press, debounce latency, release tail
    pushExp(0);
    nif.keys = 12'h001;
    cyc(3);
    chk("ksEarly", nif.key_stable, 0);
    waitKs(12'h001, 30, "ks0");
    cyc(2);
    chk("ld0Done", expQ.size(), 0);
    chk("en0", nif.gen_en, 1);
    chk("hp0", nif.half_period, 47778);
    nif.keys = '0;
    waitKs(12'h000, 30, "ks0Rel");
    cyc(8);
    chk("relHold0", nif.gen_en, 1);
    cyc(8);
    chk("relIdle0", nif.gen_en, 0);
    chk("relHpHold", nif.half_period, 47778);

    // one-tick glitch on key 5
    ld = loadCnt;
    ksOr = '0;
    enOr = 1'b0;
    nif.keys = 12'h020;
    repeat (4) begin
      cyc(1);
      ksOr |= nif.key_stable;
      enOr |= nif.gen_en;
    end
    nif.keys = '0;
    repeat (20) begin
      cyc(1);
      ksOr |= nif.key_stable;
      enOr |= nif.gen_en;
    end
    chk("glitchKs", ksOr, 0);
    chk("glitchEn", enOr, 0);
    chk("glitchLoads", loadCnt, ld);

    // hold key 9, add key 2: no preemption
    pushExp(9);
    nif.keys = 12'h200;
    waitKs(12'h200, 30, "ks9");
    cyc(2);
    ld = loadCnt;
    nif.keys = 12'h204;
    waitKs(12'h204, 30, "ks9and2");
    cyc(8);
    chk("noPreemptLd", loadCnt, ld);
    chk("noPreemptIdx", nif.note_idx, 9);
    chk("noPreemptHp", nif.half_period, 28409);

    // release everything: 3-tick tail then idle
    nif.keys = '0;
    waitKs(12'h000, 30, "ks9Rel");
    cyc(8);
    chk("relHold9", nif.gen_en, 1);
    cyc(8);
    chk("relIdle9", nif.gen_en, 0);

    // release key 9 while key 11 held: re-trigger from RELEASE
    pushExp(9);
    nif.keys = 12'h200;
    waitKs(12'h200, 30, "ks9b");
    cyc(2);
    nif.keys = 12'hA00;
    waitKs(12'hA00, 30, "ks9and11");
    pushExp(11);
    nif.keys = 12'h800;
    waitKs(12'h800, 30, "ks11");
    cyc(3);
    chk("retrigDone", expQ.size(), 0);
    chk("retrigIdx", nif.note_idx, 11);
    chk("retrigHp", nif.half_period, 25310);
    chk("retrigEn", nif.gen_en, 1);
    nif.keys = '0;
    waitKs(12'h000, 30, "ks11Rel");
    cyc(20);
    chk("idle11", nif.gen_en, 0);

    // simultaneous keys 3 and 7: lowest wins
    pushExp(3);
    nif.keys = 12'h088;
    waitKs(12'h088, 30, "ks3and7");
    cyc(2);
    chk("simulIdx", nif.note_idx, 3);
    chk("simulHp", nif.half_period, 40177);
    nif.keys = '0;
    waitKs(12'h000, 30, "ks37Rel");
    cyc(20);

    // reset mid-PLAY, then re-debounce
    pushExp(4);
    nif.keys = 12'h010;
    waitKs(12'h010, 30, "ks4");
    cyc(3);
    chk("play4En", nif.gen_en, 1);
    rst = 1'b1;
    #1;
    chk("asyncEn", nif.gen_en, 0);
    chk("asyncLoad", nif.gen_load, 0);
    chk("asyncIdx", nif.note_idx, 0);
    chk("asyncHp", nif.half_period, 47778);
    chk("asyncKs", nif.key_stable, 0);
    cyc(2);
    rst = 1'b0;
    ld = loadCnt;
    pushExp(4);
    cyc(3);
    chk("noEarlyLd", loadCnt, ld);
    chk("noEarlyKs", nif.key_stable, 0);
    waitLoad(ld + 1, 30, "reLoad4");
    cyc(2);
    chk("re4Idx", nif.note_idx, 4);
    chk("re4Hp", nif.half_period, 37922);
    chk("re4En", nif.gen_en, 1);
    nif.keys = '0;
    cyc(30);
    chk("finalIdle", nif.gen_en, 0);
    chk("qEmpty", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
